// File: rtl/word_deserializer.sv
// word_deserializer
// Assembles up to BEATS narrow WIDTH-bit beats from a valid/ready input
// stream into one packed word, presented on a valid/ready output.
//
// Ports:
//   clock      system clock
//   reset      asynchronous, active-high reset
//   clear      synchronous abort, discards the partial or held word
//   in_data    input beat
//   in_valid   in_data is valid
//   in_last    beat ends the frame early (qualified by in_valid)
//   in_ready   block accepts a beat this cycle
//   out_data   assembled word, unfilled slots are zero
//   out_count  number of valid beats in out_data (1..BEATS)
//   out_valid  out_data / out_count are valid
//   out_ready  consumer takes the word this cycle
//
// Build option:
//   WORD_DESER_MSB_FIRST_EN  first beat lands in the top slot and short
//                            words are left-aligned. Default: first beat
//                            in slot 0, short words right-aligned.
//
// state | meaning
// ------+-----------------------------------------------
// FILL  | collecting beats into slot idx, in_ready=1
// HOLD  | completed word presented, in_ready=out_ready
module word_deserializer #(
  parameter int WIDTH = 8,
  parameter int BEATS = 4
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             clear,
  input  logic [WIDTH-1:0]                 in_data,
  input  logic                             in_valid,
  input  logic                             in_last,
  output logic                             in_ready,
  output logic [BEATS-1:0][WIDTH-1:0]      out_data,
  output logic [$clog2(BEATS+1)-1:0]       out_count,
  output logic                             out_valid,
  input  logic                             out_ready
);

  localparam int IDX_W = $clog2(BEATS);
  localparam int CNT_W = $clog2(BEATS+1);

  typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_t;

  state_t                        state, state_n;
  logic [IDX_W-1:0]              idx, idx_n;
  logic [BEATS-1:0][WIDTH-1:0]   slots, slots_n;
  logic [CNT_W-1:0]              count, count_n;
  logic                          accept;

  // Logical beat index to physical slot.
  function automatic logic [IDX_W-1:0] slot_of(input logic [IDX_W-1:0] k);
`ifdef WORD_DESER_MSB_FIRST_EN
    return IDX_W'(BEATS-1) - k;
`else
    return k;
`endif
  endfunction

  // in_ready only looks at clear, out_ready and registered state, so the
  // output side never sees a combinational path from the in_* inputs.
  always_comb begin
    if (clear)
      in_ready = 1'b0;
    else if (state == FILL)
      in_ready = 1'b1;
    else
      in_ready = out_ready;
  end

  assign accept    = in_valid && in_ready;
  assign out_valid = (state == HOLD);
  assign out_data  = slots;
  assign out_count = count;

  always_comb begin
    state_n = state;
    idx_n   = idx;
    slots_n = slots;
    count_n = count;
    if (clear) begin
      state_n = FILL;
      idx_n   = '0;
      slots_n = '0;
      count_n = '0;
    end else begin
      case (state)
        FILL: begin
          if (accept) begin
            slots_n[slot_of(idx)] = in_data;
            if (idx == IDX_W'(BEATS-1) || in_last) begin
              state_n = HOLD;
              count_n = CNT_W'(idx) + CNT_W'(1);
              idx_n   = '0;
            end else begin
              idx_n = idx + IDX_W'(1);
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            // Handoff: the next frame starts from an all-zero word.
            slots_n = '0;
            count_n = '0;
            idx_n   = '0;
            state_n = FILL;
            if (accept) begin
              slots_n[slot_of('0)] = in_data;
              if (in_last) begin
                // Single-beat frame right behind the previous one.
                state_n = HOLD;
                count_n = CNT_W'(1);
              end else begin
                idx_n = IDX_W'(1);
              end
            end
          end
        end
        default: begin
          state_n = FILL;
          idx_n   = '0;
          slots_n = '0;
          count_n = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= FILL;
      idx   <= '0;
      slots <= '0;
      count <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      slots <= slots_n;
      count <= count_n;
    end
  end

endmodule

// File: tb/tb_word_deserializer.sv
module tb_word_deserializer;

  logic              clock;
  logic              reset;
  logic              clear;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_last;
  logic              in_ready;
  logic [3:0][7:0]   out_data;
  logic [2:0]        out_count;
  logic              out_valid;
  logic              out_ready;

  int checks = 0;
  int errors = 0;

  word_deserializer #(.WIDTH(8), .BEATS(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .clear     (clear),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_count (out_count),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Expected word written in default slot order; the MSB-first build
  // stores logical beat k in slot 3-k, i.e. the same word byte-reversed.
  function automatic logic [31:0] exp_word(input logic [31:0] w);
`ifdef WORD_DESER_MSB_FIRST_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic last);
    in_data  = d;
    in_valid = 1'b1;
    in_last  = last;
    cycle();
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
    cycle();
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; in_data = '0; in_valid = 1'b0;
    in_last = 1'b0; out_ready = 1'b1;
    #12;
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_count", {29'd0, out_count}, 32'd0);
    check("rst_data", out_data, 32'd0);
    reset = 1'b0;
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    cycle();

    // Full word
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    check("full_pre_valid", {31'd0, out_valid}, 32'd0);
    send(8'h44, 1'b0);
    check("full_valid", {31'd0, out_valid}, 32'd1);
    check("full_data", out_data, exp_word(32'h44332211));
    check("full_count", {29'd0, out_count}, 32'd4);
    idle();
    check("full_handoff", {31'd0, out_valid}, 32'd0);
    check("full_zeroed", out_data, 32'd0);

    // Early end
    send(8'hAA, 1'b0);
    send(8'hBB, 1'b1);
    check("early_valid", {31'd0, out_valid}, 32'd1);
    check("early_data", out_data, exp_word(32'h0000BBAA));
    check("early_count", {29'd0, out_count}, 32'd2);
    idle();
    check("early_handoff", {31'd0, out_valid}, 32'd0);

    // Back-pressure
    out_ready = 1'b0;
    send(8'hA1, 1'b0);
    send(8'hA2, 1'b0);
    send(8'hA3, 1'b0);
    send(8'hA4, 1'b0);
    in_data = 8'h55; in_valid = 1'b1; in_last = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_valid", {31'd0, out_valid}, 32'd1);
      check("bp_data", out_data, exp_word(32'hA4A3A2A1));
      cycle();
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", {31'd0, in_ready}, 32'd1);
    cycle();
    check("bp_after_valid", {31'd0, out_valid}, 32'd0);
    check("bp_slot0", out_data, exp_word(32'h00000055));
    send(8'h66, 1'b0);
    send(8'h77, 1'b0);
    send(8'h88, 1'b0);
    check("bp_next_valid", {31'd0, out_valid}, 32'd1);
    check("bp_next_data", out_data, exp_word(32'h88776655));
    check("bp_next_count", {29'd0, out_count}, 32'd4);
    idle();

    // Back-to-back, no bubble
    for (int b = 1; b <= 8; b++) begin
      in_data = 8'(b); in_valid = 1'b1; in_last = 1'b0;
      #1;
      check("b2b_in_ready", {31'd0, in_ready}, 32'd1);
      cycle();
      if (b == 4) begin
        check("b2b_w0_valid", {31'd0, out_valid}, 32'd1);
        check("b2b_w0_data", out_data, exp_word(32'h04030201));
      end
      if (b == 5)
        check("b2b_w0_taken", {31'd0, out_valid}, 32'd0);
    end
    check("b2b_w1_valid", {31'd0, out_valid}, 32'd1);
    check("b2b_w1_data", out_data, exp_word(32'h08070605));
    // Single-beat frame accepted during handoff stays in HOLD
    send(8'h09, 1'b1);
    check("zb_valid", {31'd0, out_valid}, 32'd1);
    check("zb_count", {29'd0, out_count}, 32'd1);
    check("zb_data", out_data, exp_word(32'h00000009));
    idle();
    check("zb_taken", {31'd0, out_valid}, 32'd0);

    // Clear
    send(8'hC1, 1'b0);
    send(8'hC2, 1'b0);
    send(8'hC3, 1'b0);
    clear = 1'b1; in_data = 8'hEE; in_valid = 1'b1; in_last = 1'b0;
    #1;
    check("clr_in_ready", {31'd0, in_ready}, 32'd0);
    cycle();
    clear = 1'b0;
    check("clr_data", out_data, 32'd0);
    check("clr_count", {29'd0, out_count}, 32'd0);
    check("clr_valid", {31'd0, out_valid}, 32'd0);
    send(8'hD1, 1'b0);
    send(8'hD2, 1'b0);
    send(8'hD3, 1'b0);
    send(8'hD4, 1'b0);
    check("clr_new_data", out_data, exp_word(32'hD4D3D2D1));
    check("clr_new_count", {29'd0, out_count}, 32'd4);
    idle();

    // Reset mid-HOLD
    out_ready = 1'b0;
    send(8'hF1, 1'b0);
    send(8'hF2, 1'b1);
    in_valid = 1'b0; in_last = 1'b0;
    check("rh_valid_before", {31'd0, out_valid}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("rh_valid", {31'd0, out_valid}, 32'd0);
    check("rh_count", {29'd0, out_count}, 32'd0);
    check("rh_data", out_data, 32'd0);
    reset = 1'b0;
    #1;
    check("rh_in_ready", {31'd0, in_ready}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
